// File: rtl/audiodactransmitter.sv
// audiodactransmitter
//   Serializes 32-bit stereo words from a non-show-ahead playback FIFO onto the
//   codec DAC data line. Left channel = upper half of the word, right channel =
//   lower half. The first word bit is sent at the LRCK transition edge, so the
//   codec, sampling on the next rising BCLK, sees the I2S one-bit delay.
//   Frames that find no word ready are sent as silence and counted.
//
// Ports
//   AUD_BCLK        in   codec bit clock; only clock, rising edge
//   reset_n         in   asynchronous active-low reset
//   AUD_DAC_CLK     in   codec LR clock, 1 = left, 0 = right
//   rdempty_sig     in   FIFO empty flag
//   q_sig           in   FIFO read data, valid the cycle after rdreq_sig
//   rdreq_sig       out  FIFO read request, single-cycle pulse per word
//   AUD_DAC_DATA    out  registered serial data to the codec
//   underrun_count  out  saturating count of muted frames
module audiodactransmitter #(
  parameter int unsigned dataLength = 16
) (
  input  logic                      AUD_BCLK,
  input  logic                      reset_n,
  input  logic                      AUD_DAC_CLK,
  input  logic                      rdempty_sig,
  input  logic [2*dataLength-1:0]   q_sig,
  output logic                      rdreq_sig,
  output logic                      AUD_DAC_DATA,
  output logic [15:0]               underrun_count
);

  localparam int unsigned WordW = 2 * dataLength;
  localparam int unsigned CntW  = $clog2(dataLength + 1);
  localparam int unsigned IdxW  = $clog2(WordW);

  typedef enum logic [0:0] {StSync, StRun} state_e;

  state_e              r_state, w_state_next;
  logic                r_lrck;
  logic                r_rdreq;
  logic                r_cap;        // read issued last cycle, q_sig valid now
  logic [WordW-1:0]    r_next;
  logic                r_next_valid;
  logic [WordW-1:0]    r_frame;
  logic                r_left;       // channel currently being sent
  logic [CntW-1:0]     r_cnt;
  logic                r_data;
  logic [15:0]         r_underrun;

  logic                w_left_edge;
  logic                w_right_edge;
  logic                w_rdreq_next;
  logic [WordW-1:0]    w_load_word;
  logic [IdxW-1:0]     w_base;
  logic [IdxW-1:0]     w_idx;

  assign w_left_edge  = AUD_DAC_CLK & ~r_lrck;
  assign w_right_edge = ~AUD_DAC_CLK & r_lrck;

  // One read in flight at a time; the registered request plus r_cap covers the
  // two cycles between issuing a read and capturing its data.
  assign w_rdreq_next = ~r_next_valid & ~r_rdreq & ~r_cap & ~rdempty_sig;

  // A word still being captured at the left edge is not usable for this frame.
  assign w_load_word  = r_next_valid ? r_next : '0;

  // Next bit to send: channel MSB minus bits already sent.
  always_comb begin
    w_base = r_left ? IdxW'(WordW - 1) : IdxW'(dataLength - 1);
    w_idx  = w_base - IdxW'(r_cnt) - IdxW'(1);
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StSync:  if (w_left_edge) w_state_next = StRun;
      StRun:   w_state_next = StRun;
      default: w_state_next = StSync;
    endcase
  end

  always_ff @(posedge AUD_BCLK or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StSync;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge AUD_BCLK or negedge reset_n) begin
    if (!reset_n) begin
      r_lrck       <= 1'b1;
      r_rdreq      <= 1'b0;
      r_cap        <= 1'b0;
      r_next       <= '0;
      r_next_valid <= 1'b0;
      r_frame      <= '0;
      r_left       <= 1'b1;
      r_cnt        <= '0;
      r_data       <= 1'b0;
      r_underrun   <= '0;
    end else begin
      r_lrck  <= AUD_DAC_CLK;
      r_rdreq <= w_rdreq_next;
      r_cap   <= r_rdreq;

      // Capture and consume never coincide: no read is issued while valid.
      if (r_cap) begin
        r_next       <= q_sig;
        r_next_valid <= 1'b1;
      end else if (w_left_edge) begin
        r_next_valid <= 1'b0;
      end

      if (w_left_edge) begin
        r_frame <= w_load_word;
        r_left  <= 1'b1;
        r_cnt   <= '0;
        r_data  <= w_load_word[WordW-1];
        if (!r_next_valid && (r_underrun != 16'hFFFF)) begin
          r_underrun <= r_underrun + 16'd1;
        end
      end else if ((r_state == StRun) && w_right_edge) begin
        r_left <= 1'b0;
        r_cnt  <= '0;
        r_data <= r_frame[dataLength-1];
      end else if (r_state == StRun) begin
        if (r_cnt != CntW'(dataLength)) begin
          r_cnt <= r_cnt + CntW'(1);
        end
        r_data <= (r_cnt < CntW'(dataLength - 1)) ? r_frame[w_idx] : 1'b0;
      end else begin
        r_data <= 1'b0;
      end
    end
  end

  assign rdreq_sig      = r_rdreq;
  assign AUD_DAC_DATA   = r_data;
  assign underrun_count = r_underrun;

endmodule

// File: doc/audiodactransmitter.md
# AudioDacTransmitter

Serializes 32-bit stereo samples from a FIFO onto the codec DAC serial data line. Left channel is taken from the 16 MSBs and right channel from the 16 LSBs, the same word packing the ADC capture path produces. The block sits between the playback FIFO read port and the audio codec DAC pins, clocked by the codec bit clock. Empty-FIFO frames are muted and counted.

## Interface
Parameters:
- dataLength, 16: bits per channel; word width is 2*dataLength.

Ports:
- AUD_BCLK  input  1  audio bit clock; the single clock of the block, all logic on its rising edge.
- reset_n  input  1  reset, asynchronous and active-low.
- AUD_DAC_CLK  input  1  DAC LR clock from codec; 1 = left channel, 0 = right channel.
- rdempty_sig  input  1  FIFO empty indicator.
- q_sig  input  32  FIFO read data, valid the cycle after rdreq_sig (normal, non-show-ahead FIFO).
- rdreq_sig  output  1  FIFO read request, one-cycle pulse per word.
- AUD_DAC_DATA  output  1  serial data to the codec, registered.
- underrun_count  output  16  saturating count of muted frames.

## Operation
- lrck_q: AUD_DAC_CLK registered every cycle; resets to 1.
  - Left edge = AUD_DAC_CLK & !lrck_q.
  - Right edge = !AUD_DAC_CLK & lrck_q.
- State SYNC (reset state):
  - AUD_DAC_DATA = 0; right edges are ignored.
  - Prefetch is allowed.
  - Exits to RUN on the first left edge.
- State RUN:
  - Serializes continuously.
  - Returns to SYNC only on reset.
- Prefetch buffer: next_reg[31:0] plus next_valid.
  - rdreq_sig pulses when next_valid=0, no read is outstanding, and rdempty_sig=0.
  - On the following cycle, q_sig is captured into next_reg and next_valid is set to 1.
  - rdreq_sig is never asserted while rdempty_sig=1, and never on two consecutive cycles.
- Left edge (SYNC→RUN or in RUN):
  - If next_valid=1: frame_reg <= next_reg, and next_valid clears.
  - Otherwise: frame_reg <= 0 and underrun_count increments, saturating at 0xFFFF.
  - A capture landing on the same cycle as a left edge is held for the following frame; the current frame is muted and counted.
- Bit counter: 5-bit.
  - Cleared to 0 on every left or right edge.
  - Increments per bit sent; saturates at dataLength.
- Data bit order, left channel: bit 31 at the edge, then 30 … 16.
- Data bit order, right channel: bit 15 at the edge, then 14 … 0.
- Once dataLength bits have been sent in a half-frame, AUD_DAC_DATA = 0 until the next edge.
- Short half-frame (edge before 16 bits sent): remaining bits are dropped; the new channel starts at its MSB.
- Reset mid-operation: all state is cleared immediately.
  - Any prefetched word is discarded.
  - Playback restarts at the next left edge after release.

## Timing
- Reset values: AUD_DAC_DATA=0, rdreq_sig=0, underrun_count=0, next_valid=0, lrck_q=1, state SYNC, counter 0.
- Left edge detected at rising edge N:
  - AUD_DAC_DATA <= frame bit 31 at edge N.
  - Bit 31−k is driven at edge N+k for k = 0..15.
  - AUD_DAC_DATA is 0 from edge N+16 onward.
  - The codec samples on the rising edge, so the MSB is sampled at edge N+1. This gives the I2S one-bit delay after the LRCK transition.
- Right edge at edge M: bit 15−k is driven at edge M+k; 0 from M+16.
- The first bit of the left channel uses the word loaded at the same edge (bypass into the output register).
- Fetch latency:
  - rdreq_sig is asserted the cycle after next_valid clears (FIFO non-empty).
  - next_valid=1 two cycles after that.
  - A refill therefore completes within 3 BCLKs of the left edge, well before the next frame at ≥ 2×16 BCLK per frame.
- The block has no throughput stall; the codec LRCK paces everything.

## Test plan
1. **Nominal stereo word.** Reset, then FIFO holds 0xA5A53C3C, LRCK at 32 BCLK per half, first left edge.
   - Exactly one rdreq_sig pulse, issued before that edge.
   - Left bits sent 1010010110100101, right bits 0011110000111100.
   - Zeros for bits 17..32 of each half.
2. **Underrun and recovery.** FIFO empty at the left edge.
   - Entire frame is 0 and underrun_count goes 0→1.
   - Push 0xFFFF0001 mid-frame → next frame left = all ones, right = 0x0001; count stays 1.
3. **Reset mid-frame.** Assert reset_n=0 at left bit 7 with one word prefetched.
   - AUD_DAC_DATA=0, rdreq_sig=0, underrun_count=0 without waiting for a clock edge.
   - After release, data stays 0 through the right half until the next rising LRCK.
   - A new rdreq_sig is issued for that frame.
4. **Short half-frames.** 10 BCLK per half-frame with word 0x8001FFFE.
   - Left sends 1000000000 (bits 31..22).
   - Right sends 1111111111 (bits 15..6).
   - No counter wrap, no extra rdreq_sig.
5. **Back-to-back words.** Four words queued, six frames run.
   - Frames 1–4 play in FIFO order, with four rdreq_sig pulses, none while rdempty_sig=1.
   - Frames 5–6 are muted and underrun_count = 2.
